accel_axis_packetizer: RTL

ACCEL_AXIS_PACKETIZER -- requirements
Module: accel_axis_packetizer

---
 rtl/accel_pkg.sv | 20 ++
 rtl/accel_sync_fifo.sv | 63 ++++++
 rtl/accel_axis_packetizer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/accel_pkg.sv
// ---------------------------------------------------------------------------
// accel_pkg
// Shared definitions for the accelerator AXI4-Stream packetizer slice.
//   ACCEL_DATA_W / ACCEL_ID_W / ACCEL_DEST_W / ACCEL_DEPTH : parameter defaults
//   accel_state_t : packetizer FSM state encoding (IDLE, STREAM, DRAIN)
// ---------------------------------------------------------------------------
package accel_pkg;

  localparam int ACCEL_DATA_W = 32;
  localparam int ACCEL_ID_W   = 8;
  localparam int ACCEL_DEST_W = 4;
  localparam int ACCEL_DEPTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } accel_state_t;

endpackage

// File: rtl/accel_sync_fifo.sv
// ---------------------------------------------------------------------------
// accel_sync_fifo
// Single-clock FIFO with a registered occupancy count. The head word is read
// combinationally from storage, so it stays stable until it is popped.
// Ports:
//   ACLK, ARESETN     clock, asynchronous active-low reset (pointers/count)
//   wr_en, wr_data    push request and data (ignored when full)
//   rd_en, rd_data    pop request (ignored when empty) and head word
//   full, empty       occupancy flags
//   count             number of stored words, 0..DEPTH
// ---------------------------------------------------------------------------
module accel_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doWrite;
  logic             doRead;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign doWrite = wr_en && !full;
  assign doRead  = rd_en && !empty;
  assign rd_data = mem[rdPtr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + 1'b1;
      if (doRead)  rdPtr <= rdPtr + 1'b1;
      case ({doWrite, doRead})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset: resetting the pointers discards the contents.
  always_ff @(posedge ACLK) begin
    if (doWrite) mem[wrPtr] <= wr_data;
  end

endmodule

// File: rtl/accel_axis_packetizer.sv
// ---------------------------------------------------------------------------
// accel_axis_packetizer
// Turns the core's result stream into AXI4-Stream packets. Each run is armed
// by cfg_start; words are buffered in a FIFO and TLAST is inserted every
// cfg_pkt_len beats (0 = no length boundary) and on the core's final word.
// Ports:
//   ACLK, ARESETN                 clock, asynchronous active-low reset
//   cfg_start, cfg_pkt_len,
//   cfg_id, cfg_dest              run configuration (sampled only in IDLE)
//   in_valid/in_ready, in_data,
//   in_last                       core result handshake
//   m_axis_*                      AXI4-Stream master
//   busy, done, pkt_count         status
//   dbg_state, dbg_fifo_count     FSM state and FIFO occupancy for observation
//
// Handshake rule (both interfaces): a word transfers on a rising edge where
// valid and ready are both high; valid never waits on ready, and the payload
// is held stable while valid is high and ready is low.
// ---------------------------------------------------------------------------
module accel_axis_packetizer
  import accel_pkg::*;
#(
  parameter int DATA_W = ACCEL_DATA_W,
  parameter int ID_W   = ACCEL_ID_W,
  parameter int DEST_W = ACCEL_DEST_W,
  parameter int DEPTH  = ACCEL_DEPTH
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   cfg_start,
  input  logic [15:0]            cfg_pkt_len,
  input  logic [ID_W-1:0]        cfg_id,
  input  logic [DEST_W-1:0]      cfg_dest,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_last,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [DATA_W-1:0]      m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic [DATA_W/8-1:0]    m_axis_tkeep,
  output logic [DATA_W/8-1:0]    m_axis_tstrb,
  output logic [ID_W-1:0]        m_axis_tid,
  output logic [DEST_W-1:0]      m_axis_tdest,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            pkt_count,
  output accel_state_t           dbg_state,
  output logic [$clog2(DEPTH):0] dbg_fifo_count
);

  accel_state_t          state;
  accel_state_t          nextState;
  logic [15:0]           pktLen;
  logic [ID_W-1:0]       runId;
  logic [DEST_W-1:0]     runDest;
  logic [15:0]           beatCnt;
  logic                  startRun;
  logic                  inHs;
  logic                  outHs;
  logic                  tlastBit;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic [DATA_W:0]       fifoHead;
  logic [$clog2(DEPTH):0] fifoCount;

  // cfg_start outside IDLE is simply not looked at.
  assign startRun = (state == ST_IDLE) && cfg_start;

  // Built from registered state and FIFO occupancy only; m_axis_tready never
  // reaches in_ready combinationally.
  assign in_ready = (state == ST_STREAM) && !fifoFull;
  assign inHs     = in_valid && in_ready;
  assign tlastBit = in_last || ((pktLen != 16'd0) && (beatCnt == pktLen - 16'd1));

  assign m_axis_tvalid = !fifoEmpty;
  assign outHs         = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = fifoHead[DATA_W-1:0];
  assign m_axis_tlast  = fifoHead[DATA_W];
  assign m_axis_tkeep  = '1;
  assign m_axis_tstrb  = '1;
  assign m_axis_tid    = runId;
  assign m_axis_tdest  = runDest;

  assign busy           = (state != ST_IDLE);
  assign dbg_state      = state;
  assign dbg_fifo_count = fifoCount;

  accel_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .wr_en   (inHs),
    .wr_data ({tlastBit, in_data}),
    .rd_en   (m_axis_tready),
    .rd_data (fifoHead),
    .full    (fifoFull),
    .empty   (fifoEmpty),
    .count   (fifoCount)
  );

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= ST_IDLE;
    else          state <= nextState;
  end

  // in_ready is low in DRAIN, so an empty FIFO there means nothing is pending.
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE:   if (startRun)          nextState = ST_STREAM;
      ST_STREAM: if (inHs && in_last)   nextState = ST_DRAIN;
      ST_DRAIN:  if (fifoEmpty)         nextState = ST_IDLE;
      default:                          nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pktLen    <= '0;
      runId     <= '0;
      runDest   <= '0;
      beatCnt   <= '0;
      pkt_count <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == ST_DRAIN) && (nextState == ST_IDLE);

      if (startRun) begin
        pktLen  <= cfg_pkt_len;
        runId   <= cfg_id;
        runDest <= cfg_dest;
      end

      if (startRun)        beatCnt <= '0;
      else if (inHs)       beatCnt <= tlastBit ? 16'd0 : beatCnt + 16'd1;

      // The FIFO is always empty in IDLE, so a start never races an output TLAST.
      if (startRun)
        pkt_count <= '0;
      else if (outHs && m_axis_tlast && (pkt_count != 16'hFFFF))
        pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule
